// File: rtl/apes_pkg.sv
// rtl/apes_pkg.sv - shared edge-mode constants and FSM state encoding for the APES multi-channel counter
package apes_pkg;

    // Edge-mode encodings on edge_sel; 2'b11 falls back to rising
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;

    // Acquisition window FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LATCH = 2'd2
    } apes_state_t;

endpackage

// File: rtl/apes_edge_sync.sv
// rtl/apes_edge_sync.sv - per-channel synchroniser, history flop and edge-mode qualified strobe
module apes_edge_sync
    import apes_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d,
    input  logic [1:0] edge_sel,
    output logic       strobe
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser; history trails the synchronised output in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_hist <= w_sync_out;
        end
    end

    // Compare synchronised level against history according to the selected edge mode
    always_comb begin
        strobe = 1'b0;
        case (edge_sel)
            EDGE_FALL: strobe = r_hist & ~w_sync_out;
            EDGE_BOTH: strobe = r_hist ^ w_sync_out;
            default:   strobe = w_sync_out & ~r_hist;
        endcase
    end

endmodule

// File: rtl/apes_multi_counter.sv
// rtl/apes_multi_counter.sv - windowed multi-channel edge counter with atomic snapshot of counts and overflow
module apes_multi_counter
    import apes_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int WIN_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       d,
    input  logic [1:0]            edge_sel,
    input  logic                  sat_en,
    input  logic [WIN_W-1:0]      window_len,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [N_CH*WIDTH-1:0] q,
    output logic [N_CH-1:0]       ovf
);

    apes_state_t            r_state;
    logic [WIN_W-1:0]       r_win;
    logic                   r_busy;
    logic                   r_done;
    logic [N_CH*WIDTH-1:0]  r_q;
    logic [N_CH-1:0]        r_ovf;
    logic [WIDTH-1:0]       r_cnt [N_CH];
    logic [N_CH-1:0]        r_live_ovf;
    logic [N_CH-1:0]        w_strobe;
    logic [N_CH*WIDTH-1:0]  w_live_flat;
    logic                   w_start_ok;

    // abort wins over start when both arrive in IDLE
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;
    assign ovf  = r_ovf;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        apes_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_edge_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .d        (d[g]),
            .edge_sel (edge_sel),
            .strobe   (w_strobe[g])
        );
        assign w_live_flat[g*WIDTH +: WIDTH] = r_cnt[g];
    end

    // Window FSM with registered busy/done and the snapshot registers updated only in LATCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_win   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_ovf   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_win   <= window_len;
                        r_busy  <= 1'b1;
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_win <= WIN_W'(1)) begin
                        // A zero length behaves like a single-cycle window
                        r_state <= ST_LATCH;
                    end else begin
                        r_win <= r_win - WIN_W'(1);
                    end
                end
                ST_LATCH: begin
                    r_q     <= w_live_flat;
                    r_ovf   <= r_live_ovf;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Live counters: cleared on an accepted start, advanced on strobes only while COUNT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_live_ovf <= '0;
        end else if (w_start_ok) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_live_ovf <= '0;
        end else if (r_state == ST_COUNT) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_strobe[i]) begin
                    if (r_cnt[i] == {WIDTH{1'b1}}) begin
                        r_live_ovf[i] <= 1'b1;
                        r_cnt[i]      <= sat_en ? {WIDTH{1'b1}} : '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apes_multi_counter.sv
// tb/tb_apes_multi_counter.sv - directed self-checking bench for apes_multi_counter
module tb_apes_multi_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  d = 4'h0;
    logic [1:0]  edge_sel = 2'b00;
    logic        sat_en = 1'b0;
    logic [15:0] window_len = 16'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;

    logic        busy, done;
    logic [63:0] q;
    logic [3:0]  ovf;
    logic        busy4, done4;
    logic [15:0] q4;
    logic [3:0]  ovf4;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    apes_multi_counter #(.N_CH(4), .WIDTH(16), .WIN_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .edge_sel(edge_sel), .sat_en(sat_en),
        .window_len(window_len), .start(start), .abort(abort),
        .busy(busy), .done(done), .q(q), .ovf(ovf)
    );

    apes_multi_counter #(.N_CH(4), .WIDTH(4), .WIN_W(16), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .d(d), .edge_sel(edge_sel), .sat_en(sat_en),
        .window_len(window_len), .start(start), .abort(abort),
        .busy(busy4), .done(done4), .q(q4), .ovf(ovf4)
    );

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input logic [15:0] len);
        window_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulses(input logic [3:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            d = d | m;
            tick(); tick();
            d = d & ~m;
            tick(); tick();
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            tick();
            if (done) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_done_timeout: done=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; d = 4'hF; edge_sel = 2'b00; sat_en = 1'b0;
        window_len = 16'd0; start = 1'b0; abort = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
        checks++; if (q !== 64'h0) begin errors++; $display("FAIL reset_q: got %h exp 0", q); end
        checks++; if (ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %h exp 0", ovf); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL reset_no_done: got %0d exp 0", done_cnt); end
    endtask

    task automatic test_rise_count();
        int dc;
        d = 4'h0;
        repeat (4) tick();
        dc = done_cnt;
        start_win(16'd100);
        pulses(4'b0001, 10);
        wait_done(150, "rise");
        tick(); tick();
        checks++; if (done_cnt - dc !== 1) begin errors++; $display("FAIL rise_done_once: got %0d exp 1", done_cnt - dc); end
        checks++; if (q !== 64'h0000_0000_0000_000A) begin errors++; $display("FAIL rise_q: got %h exp 000000000000000a", q); end
        checks++; if (ovf !== 4'h0) begin errors++; $display("FAIL rise_ovf: got %h exp 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rise_busy_after: got %b exp 0", busy); end
    endtask

    task automatic test_edge_modes();
        edge_sel = 2'b10;
        start_win(16'd100);
        pulses(4'b0100, 7);
        wait_done(150, "both");
        checks++; if (q !== 64'h0000_000E_0000_0000) begin errors++; $display("FAIL both_q: got %h exp 0000000e00000000", q); end
        tick();
        edge_sel = 2'b01;
        start_win(16'd100);
        pulses(4'b0100, 7);
        wait_done(150, "fall");
        checks++; if (q !== 64'h0000_0007_0000_0000) begin errors++; $display("FAIL fall_q: got %h exp 0000000700000000", q); end
        tick();
        edge_sel = 2'b00;
    endtask

    task automatic test_wrap_sat();
        sat_en = 1'b0;
        start_win(16'd100);
        pulses(4'b0010, 20);
        wait_done(150, "wrap");
        checks++; if (q4 !== 16'h0040) begin errors++; $display("FAIL wrap_q4: got %h exp 0040", q4); end
        checks++; if (ovf4 !== 4'b0010) begin errors++; $display("FAIL wrap_ovf4: got %b exp 0010", ovf4); end
        checks++; if (q !== 64'h0000_0000_0014_0000) begin errors++; $display("FAIL wrap_q16: got %h exp 0000000000140000", q); end
        checks++; if (ovf !== 4'h0) begin errors++; $display("FAIL wrap_ovf16: got %b exp 0000", ovf); end
        tick();
        sat_en = 1'b1;
        start_win(16'd100);
        pulses(4'b0010, 20);
        wait_done(150, "sat");
        checks++; if (q4 !== 16'h00F0) begin errors++; $display("FAIL sat_q4: got %h exp 00f0", q4); end
        checks++; if (ovf4 !== 4'b0010) begin errors++; $display("FAIL sat_ovf4: got %b exp 0010", ovf4); end
        tick();
        sat_en = 1'b0;
    endtask

    task automatic test_abort();
        int dc;
        dc = done_cnt;
        start_win(16'd50);
        pulses(4'b0001, 4);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
        repeat (60) tick();
        checks++; if (done_cnt !== dc) begin errors++; $display("FAIL abort_no_done: got %0d dones exp 0", done_cnt - dc); end
        checks++; if (q !== 64'h0000_0000_0014_0000) begin errors++; $display("FAIL abort_q_kept: got %h exp 0000000000140000", q); end
        checks++; if (ovf !== 4'h0) begin errors++; $display("FAIL abort_ovf_kept: got %b exp 0000", ovf); end
        window_len = 16'd5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle: busy got %b exp 0", busy); end
        repeat (10) tick();
        checks++; if (done_cnt !== dc) begin errors++; $display("FAIL abort_start_no_done: got %0d dones exp 0", done_cnt - dc); end
    endtask

    task automatic test_reset_mid_count();
        d = 4'h0;
        start_win(16'd100);
        pulses(4'b1000, 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b exp 1", busy); end
        rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b exp 0", done); end
        checks++; if (q !== 64'h0) begin errors++; $display("FAIL midrst_q: got %h exp 0", q); end
        checks++; if (q4 !== 16'h0) begin errors++; $display("FAIL midrst_q4: got %h exp 0", q4); end
        checks++; if (ovf4 !== 4'h0) begin errors++; $display("FAIL midrst_ovf4: got %b exp 0000", ovf4); end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_short_windows();
        logic [15:0] lens [3];
        int          exp_n [3];
        int          bc, da;
        lens  = '{16'd0, 16'd1, 16'd5};
        exp_n = '{2, 2, 6};
        for (int i = 0; i < 3; i++) begin
            window_len = lens[i];
            start = 1'b1;
            tick();
            start = 1'b0;
            bc = 0;
            da = -1;
            for (int k = 0; k < 12; k++) begin
                if (busy) bc++;
                if (done && da < 0) da = k;
                tick();
            end
            checks++; if (bc !== exp_n[i]) begin errors++; $display("FAIL short_busy_len%0d: got %0d cycles exp %0d", lens[i], bc, exp_n[i]); end
            checks++; if (da !== exp_n[i]) begin errors++; $display("FAIL short_done_len%0d: got sample %0d exp %0d", lens[i], da, exp_n[i]); end
        end
    endtask

    task automatic test_back_to_back();
        d = 4'h0;
        edge_sel = 2'b00;
        start_win(16'd20);
        pulses(4'b1000, 2);
        wait_done(40, "b2b_first");
        checks++; if (q !== 64'h0002_0000_0000_0000) begin errors++; $display("FAIL b2b_first_q: got %h exp 0002000000000000", q); end
        window_len = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b exp 1", busy); end
        pulses(4'b1000, 3);
        wait_done(40, "b2b_second");
        checks++; if (q !== 64'h0003_0000_0000_0000) begin errors++; $display("FAIL b2b_second_q: got %h exp 0003000000000000", q); end
    endtask

    initial begin
        test_reset();
        test_rise_count();
        test_edge_modes();
        test_wrap_sat();
        test_abort();
        test_reset_mid_count();
        test_short_windows();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
